axi_wr_sram_slave: RTL



---
 rtl/axi_pkg.sv | 29 ++
 rtl/axi_burst_addr.sv | 37 +++
 rtl/axi_wr_sram_slave.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state for the SRAM-side write (and later read) responders.
// Lane-address width is derived from the byte-strobe width of the data bus.
package axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_RESP
   } state_e;

   localparam int DEF_STRB_WIDTH = 4;
   localparam int DEF_LANE_W     = $clog2(DEF_STRB_WIDTH);

   function automatic int lane_width(input int strb_width);
      return $clog2(strb_width);
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
// Arithmetic is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [2:0]            i_size,
   input  logic [7:0]            i_len,
   input  logic [1:0]            i_burst,
   output logic [ADDR_WIDTH-1:0] o_next_addr
);

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] w_step;
   logic [ADDR_WIDTH-1:0] w_bound;
   logic [ADDR_WIDTH-1:0] w_incr;
   logic [ADDR_WIDTH-1:0] w_wrap;

   assign w_step  = ONE << i_size;
   assign w_bound = (ADDR_WIDTH'(i_len) + ONE) << i_size;
   assign w_incr  = (i_addr & ~(w_step - ONE)) + w_step;
   // Upper bits stay pinned to the wrap window; only the offset inside it advances.
   assign w_wrap  = (i_addr & ~(w_bound - ONE)) | ((i_addr + w_step) & (w_bound - ONE));

   always_comb begin
      o_next_addr = i_addr;
      case (i_burst)
         BURST_INCR: o_next_addr = w_incr;
         BURST_WRAP: o_next_addr = w_wrap;
         default:    o_next_addr = i_addr;
      endcase
   end

endmodule

// File: rtl/axi_wr_sram_slave.sv
// AXI4 write responder (one burst in flight) driving a registered one-cycle SRAM write port.
// Beats are consumed even when the burst is in error; only the SRAM strobe is suppressed.
module axi_wr_sram_slave
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int ID_WIDTH       = 4,
   parameter int MEM_ADDR_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ID_WIDTH-1:0]       s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   input  logic [1:0]                s_axi_awburst,
   input  logic [2:0]                s_axi_awprot,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [STRB_WIDTH-1:0]     s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [ID_WIDTH-1:0]       s_axi_bid,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [STRB_WIDTH-1:0]     mem_wstrb
);

   localparam int LANE_BITS = lane_width(STRB_WIDTH);

   state_e                r_state;
   state_e                w_next_state;
   logic [ID_WIDTH-1:0]   r_id;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [7:0]            r_cnt;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_err;

   logic                  w_aw_fire;
   logic                  w_w_fire;
   logic                  w_aw_err;
   logic                  w_wlast_bad;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic                  w_unused_ok;

   assign w_unused_ok = ^s_axi_awprot;

   assign w_aw_fire   = s_axi_awvalid & s_axi_awready;
   assign w_w_fire    = s_axi_wvalid & s_axi_wready;
   assign w_wlast_bad = s_axi_wlast ^ (r_cnt == 8'd0);
   assign w_aw_err    = (s_axi_awsize > 3'(LANE_BITS))
                      | (s_axi_awburst == 2'b11)
                      | ((s_axi_awburst == BURST_WRAP) && !(s_axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

   assign s_axi_bid   = r_id;
   assign s_axi_bresp = r_err ? RESP_SLVERR : RESP_OKAY;

   axi_burst_addr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_burst_addr (
      .i_addr      (r_addr),
      .i_size      (r_size),
      .i_len       (r_len),
      .i_burst     (r_burst),
      .o_next_addr (w_next_addr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            s_axi_awready = 1'b1;
            if (s_axi_awvalid) w_next_state = ST_DATA;
         end
         ST_DATA: begin
            s_axi_wready = 1'b1;
            // The beat counter alone ends the burst; wlast only feeds the error flag.
            if (s_axi_wvalid && (r_cnt == 8'd0)) w_next_state = ST_RESP;
         end
         ST_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_err   <= 1'b0;
      end else if (w_aw_fire) begin
         r_id    <= s_axi_awid;
         r_addr  <= s_axi_awaddr;
         r_len   <= s_axi_awlen;
         r_cnt   <= s_axi_awlen;
         r_size  <= s_axi_awsize;
         r_burst <= s_axi_awburst;
         r_err   <= w_aw_err;
      end else if (w_w_fire) begin
         r_addr  <= w_next_addr;
         r_cnt   <= r_cnt - 8'd1;
         if (w_wlast_bad) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         mem_we <= w_w_fire & ~r_err;
         if (w_w_fire && !r_err) begin
            mem_addr  <= r_addr[LANE_BITS +: MEM_ADDR_WIDTH];
            mem_wdata <= s_axi_wdata;
            mem_wstrb <= s_axi_wstrb;
         end
      end
   end

endmodule
